// File: rtl/ble_crc_whitener.sv
// BLE link-layer bit-serial back end: appends the 24-bit CRC to the PDU and
// whitens both PDU and CRC bits before they go to the modulator.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no packet open; next accepted bit samples the seeds
// PAYLOAD | packet open, PDU bits flowing through
// CRC     | PDU done, shifting out the 24 CRC bits
module ble_crc_whitener #(
  parameter logic [23:0] C_CRC_POLY  = 24'h00065B,
  parameter int          C_CRC_WIDTH = 24
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   restart,
  input  logic [C_CRC_WIDTH-1:0] crc_init,
  input  logic [6:0]             whiten_init,
  input  logic                   whiten_en,
  input  logic                   input_tdata,
  input  logic                   input_tvalid,
  output logic                   input_tready,
  input  logic                   input_tlast,
  output logic                   output_tdata,
  output logic                   output_tvalid,
  input  logic                   output_tready,
  output logic                   output_tlast
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2
  } state_t;

  localparam logic [4:0] C_LAST_CNT = 5'(C_CRC_WIDTH - 1);

  state_t                   r_state, w_nxt_state;
  logic [C_CRC_WIDTH-1:0]   r_crc, w_nxt_crc;
  logic [6:0]               r_lfsr, w_nxt_lfsr;
  logic                     r_we, w_nxt_we;
  logic [4:0]               r_cnt, w_nxt_cnt;
  logic                     r_tdata, w_nxt_tdata;
  logic                     r_tvalid, w_nxt_tvalid;
  logic                     r_tlast, w_nxt_tlast;

  logic                     w_out_free;
  logic                     w_accept;
  logic [C_CRC_WIDTH-1:0]   w_c;
  logic [6:0]               w_w;
  logic                     w_we;
  logic                     w_fb;

  // x^7 + x^4 + 1 whitening LFSR, one step
  function automatic logic [6:0] f_lfsr_step(input logic [6:0] w);
    logic [6:0] s;
    s    = {w[5:0], w[6]};
    s[4] = w[3] ^ w[6];
    return s;
  endfunction

  assign w_out_free    = ~r_tvalid | output_tready;
  assign input_tready  = (r_state != CRC) & w_out_free;
  assign w_accept      = input_tvalid & input_tready;

  // Seeds are taken straight from the ports on the first bit of a packet
  assign w_c  = (r_state == IDLE) ? crc_init    : r_crc;
  assign w_w  = (r_state == IDLE) ? whiten_init : r_lfsr;
  assign w_we = (r_state == IDLE) ? whiten_en   : r_we;
  assign w_fb = input_tdata ^ w_c[C_CRC_WIDTH-1];

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_crc    = r_crc;
    w_nxt_lfsr   = r_lfsr;
    w_nxt_we     = r_we;
    w_nxt_cnt    = r_cnt;
    w_nxt_tdata  = r_tdata;
    w_nxt_tvalid = r_tvalid;
    w_nxt_tlast  = r_tlast;

    if (r_state != CRC) begin
      if (w_accept) begin
        w_nxt_crc    = {w_c[C_CRC_WIDTH-2:0], 1'b0} ^ (w_fb ? C_CRC_POLY : '0);
        w_nxt_lfsr   = f_lfsr_step(w_w);
        w_nxt_we     = w_we;
        w_nxt_tdata  = input_tdata ^ (w_we & w_w[6]);
        w_nxt_tvalid = 1'b1;
        w_nxt_tlast  = 1'b0;
        if (input_tlast) begin
          w_nxt_state = CRC;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_state = PAYLOAD;
        end
      end else if (w_out_free) begin
        w_nxt_tvalid = 1'b0;
        w_nxt_tlast  = 1'b0;
      end
    end else if (w_out_free) begin
      w_nxt_tdata  = r_crc[C_CRC_WIDTH-1] ^ (r_we & r_lfsr[6]);
      w_nxt_crc    = {r_crc[C_CRC_WIDTH-2:0], 1'b0};
      w_nxt_lfsr   = f_lfsr_step(r_lfsr);
      w_nxt_tvalid = 1'b1;
      w_nxt_cnt    = r_cnt + 5'd1;
      w_nxt_tlast  = 1'b0;
      if (r_cnt == C_LAST_CNT) begin
        w_nxt_tlast = 1'b1;
        w_nxt_state = IDLE;
        w_nxt_cnt   = '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_crc    <= '0;
      r_lfsr   <= '0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
      r_tdata  <= 1'b0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (restart) begin
      r_state  <= IDLE;
      r_crc    <= '0;
      r_lfsr   <= '0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
      r_tdata  <= 1'b0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_crc    <= w_nxt_crc;
      r_lfsr   <= w_nxt_lfsr;
      r_we     <= w_nxt_we;
      r_cnt    <= w_nxt_cnt;
      r_tdata  <= w_nxt_tdata;
      r_tvalid <= w_nxt_tvalid;
      r_tlast  <= w_nxt_tlast;
    end
  end

  assign output_tdata  = r_tdata;
  assign output_tvalid = r_tvalid;
  assign output_tlast  = r_tlast;

endmodule
